sram_bus_arbiter: RTL and testbench
===================================

SRAM_BUS_ARBITER -- requirements
Module: sram_bus_arbiter

Interface
REQ-001 Clock and reset SHALL be `clk` (one clock) and `rst`; reset SHALL be synchronous and active-high.
REQ-002 Parameters SHALL be none; all widths SHALL be fixed (addr/data 32, size 2, wstrb 4).
REQ-003 `clk` in 1: rising-edge clock.
REQ-004 `rst` in 1: synchronous active-high reset.
REQ-005 `inst_req` in 1, `inst_addr` in 32: instruction read request, always a word read.
REQ-006 `inst_addr_ok` out 1, `inst_data_ok` out 1, `inst_rdata` out 32: instruction-side handshakes and read data.
REQ-007 `data_req` in 1, `data_wr` in 1, `data_size` in 2, `data_wstrb` in 4: data request and its attributes.
REQ-008 `data_addr` in 32, `data_wdata` in 32: data-side address and write data.
REQ-009 `data_addr_ok` out 1, `data_data_ok` out 1, `data_rdata` out 32: data-side handshakes and read data.
REQ-010 `bus_req` out 1, `bus_wr` out 1, `bus_size` out 2, `bus_wstrb` out 4, `bus_addr` out 32, `bus_wdata` out 32: shared SRAM-like bus request.
REQ-011 `bus_addr_ok` in 1, `bus_data_ok` in 1, `bus_rdata` in 32: shared bus responses.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, ADDR and DATA, and SHALL allow at most one outstanding bus transaction.
- IDLE: if any request is present, grant one, latch its fields into registers, record the owner, and go to ADDR next cycle.
- ADDR: assert `bus_req`. On `bus_addr_ok`, pulse the owner's `*_addr_ok` in the same cycle and go to DATA.
- DATA: on `bus_data_ok`, pulse the owner's `*_data_ok` in the same cycle and go to IDLE.
REQ-013 All `bus_*` request fields SHALL be driven from the latched registers; they SHALL stay stable from entry to ADDR until `bus_addr_ok`.
REQ-014 For an inst grant, the latched fields SHALL be: wr=0, size=2'b10, wstrb=4'b0000.
REQ-015 Arbitration SHALL be round-robin.
- A single requester is granted immediately.
- On a tie, grant the requester that was not `last_owner`.
- `last_owner` updates at each grant.
REQ-016 `inst_rdata` and `data_rdata` SHALL both be combinational copies of `bus_rdata`; each is valid only while its `*_data_ok` is high.
REQ-017 The `*_addr_ok` and `*_data_ok` outputs SHALL be combinational: bus handshake AND owner match AND correct state.
REQ-018 Minimum latency SHALL be: request seen in IDLE at cycle N; `bus_req` at N+1; addr_ok at N+1 at the earliest; data_ok at N+2 at the earliest; next grant in IDLE at N+3.
REQ-019 `bus_data_ok` outside DATA SHALL be ignored, and so SHALL `bus_addr_ok` outside ADDR; neither shall cause any requester pulse.
REQ-020 Requesters SHALL hold `*_req` and their fields until they receive `*_addr_ok`.
- The arbiter samples fields only at grant.
- A request withdrawn after grant is still completed on the bus.
REQ-021 If `bus_addr_ok` and `bus_data_ok` are both high in ADDR, only addr_ok SHALL be honoured; data_ok in DATA is required to complete.
REQ-022 Simultaneous completion in DATA with new requests pending SHALL return to IDLE; re-arbitration occurs in the next cycle (no back-to-back grant).

Reset
REQ-023 On `rst`, the block SHALL enter IDLE and drive `bus_req`=0.
REQ-024 On `rst`, all latched fields SHALL be 0, `last_owner` SHALL be DATA (so inst wins the first tie), and all `*_addr_ok`/`*_data_ok` SHALL be 0.
REQ-025 Reset mid-transaction SHALL abandon the transaction; any late `bus_data_ok` arriving in IDLE SHALL be ignored per REQ-019.

Structure
REQ-026 State encodings (IDLE=2'd0, ADDR=2'd1, DATA=2'd2) and owner encodings (OWN_INST=1'b0, OWN_DATA=1'b1) SHALL live in `lib/defines.vh`.
REQ-027 The block SHALL contain one sub-module, `rr_pick2`: a combinational 2-way round-robin chooser with inputs req[1:0] and last, and outputs gnt[1:0] and valid.
REQ-028 The block SHALL sit between `mycpu_core` and the address-translated SRAM-like bus.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Post-reset tie: `inst_req` and `data_req` both high at cycle 0 with inst_addr=0xBFC00000 → inst granted; `bus_addr`=0xBFC00000 and `bus_wr`=0 at cycle 1.
- Back-to-back ties: both requesters held high for three transactions → grant order inst, data, inst.
- Data write: data_wr=1, data_addr=0x80001000, data_wdata=0xDEADBEEF, data_wstrb=4'hF, addr_ok delayed 3 cycles → bus fields stable for 4 cycles, `data_addr_ok` pulses for one cycle, `inst_addr_ok` stays 0.
- Read data routing: `bus_rdata`=0x12345678 with `bus_data_ok` in DATA owned by inst → `inst_data_ok`=1 and `inst_rdata`=0x12345678; `data_data_ok`=0.
- Reset mid-transaction: `rst` asserted in DATA, then `bus_data_ok`=1 one cycle after reset → no `*_data_ok` pulse; state IDLE; `bus_req`=0.
- Spurious handshake: `bus_data_ok` in ADDR, and `bus_addr_ok` in IDLE → ignored; no state change.

Source files
------------

// File: rtl/sram_bus_arbiter_pkg.sv
// Shared encodings and latched-request layout for the SRAM bus arbiter.
package sram_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  localparam logic [1:0] INST_SIZE = 2'b10;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_fields_t;

  // Instruction fetches are always full-word reads.
  function automatic bus_fields_t inst_fields(input logic [31:0] addr);
    bus_fields_t f;
    f.wr    = 1'b0;
    f.size  = INST_SIZE;
    f.wstrb = 4'b0000;
    f.addr  = addr;
    f.wdata = 32'h0;
    return f;
  endfunction

endpackage

// File: rtl/sram_bus_arbiter_rr_pick2.sv
// Two-way round-robin chooser: bit 0 is the inst side, bit 1 the data side.
import sram_bus_arbiter_pkg::*;

module rr_pick2 (
  input  logic [1:0] req,
  input  owner_t     last,
  output logic [1:0] gnt,
  output logic       valid
);

  always_comb begin
    gnt   = req;
    valid = |req;
    // On a tie, favour whoever did not win last time.
    if (&req) gnt = (last == OWN_DATA) ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Arbitrates inst and data SRAM-like requesters onto one shared bus,
// with at most one outstanding transaction.
import sram_bus_arbiter_pkg::*;

module sram_bus_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  state_t      state;
  owner_t      owner;
  owner_t      last_owner;
  bus_fields_t lat;
  logic [1:0]  gnt;
  logic        gnt_valid;

  rr_pick2 u_pick (
    .req   ({data_req, inst_req}),
    .last  (last_owner),
    .gnt   (gnt),
    .valid (gnt_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_INST;
      last_owner <= OWN_DATA;
      lat        <= '0;
      bus_req    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            state   <= ADDR;
            bus_req <= 1'b1;
          end
          if (gnt[0]) begin
            owner      <= OWN_INST;
            last_owner <= OWN_INST;
            lat        <= inst_fields(inst_addr);
          end else if (gnt[1]) begin
            owner      <= OWN_DATA;
            last_owner <= OWN_DATA;
            lat        <= '{wr: data_wr, size: data_size, wstrb: data_wstrb,
                            addr: data_addr, wdata: data_wdata};
          end
        end
        ADDR: begin
          if (bus_addr_ok) begin
            state   <= DATA;
            bus_req <= 1'b0;
          end
        end
        DATA: begin
          if (bus_data_ok) state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          bus_req <= 1'b0;
        end
      endcase
    end
  end

  assign bus_wr    = lat.wr;
  assign bus_size  = lat.size;
  assign bus_wstrb = lat.wstrb;
  assign bus_addr  = lat.addr;
  assign bus_wdata = lat.wdata;

  // Handshakes outside their own state are dropped here.
  assign inst_addr_ok = (state == ADDR) && bus_addr_ok && (owner == OWN_INST);
  assign data_addr_ok = (state == ADDR) && bus_addr_ok && (owner == OWN_DATA);
  assign inst_data_ok = (state == DATA) && bus_data_ok && (owner == OWN_INST);
  assign data_data_ok = (state == DATA) && bus_data_ok && (owner == OWN_DATA);

  assign inst_rdata = bus_rdata;
  assign data_rdata = bus_rdata;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed table, hand-written corner sequences and a randomized run
// against a transaction-level model of the arbiter.
module tb_sram_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic zero_inputs();
    inst_req = 0; inst_addr = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
  endtask

  // Leaves time just after a negedge with rst released.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    zero_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        ireq, dreq, aok, dok;
    logic [31:0] rdata;
    logic        e_breq, e_iaok, e_daok, e_idok, e_ddok;
    logic [31:0] e_addr;
    logic        e_wr;
  } vec_t;

  vec_t tbl[13];

  // Transaction-level reference state for the random run.
  logic        m_busy, m_addr_done, m_own, m_last;
  logic        m_wr;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata;

  initial begin
    logic in_a, in_d, e_iaok, e_daok, e_idok, e_ddok, ack_i, ack_d;

    tbl[0]  = '{1, 1, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        0};
    tbl[1]  = '{1, 1, 0, 1, 32'h0,        1, 0, 0, 0, 0, 32'hBFC00000, 0};
    tbl[2]  = '{1, 1, 1, 0, 32'h0,        1, 1, 0, 0, 0, 32'hBFC00000, 0};
    tbl[3]  = '{1, 1, 0, 1, 32'h12345678, 0, 0, 0, 1, 0, 32'h0,        0};
    tbl[4]  = '{1, 1, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        0};
    tbl[5]  = '{1, 1, 1, 0, 32'h0,        1, 0, 1, 0, 0, 32'h80001000, 1};
    tbl[6]  = '{1, 1, 0, 1, 32'hA5A5A5A5, 0, 0, 0, 0, 1, 32'h0,        0};
    tbl[7]  = '{1, 1, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        0};
    tbl[8]  = '{1, 1, 1, 0, 32'h0,        1, 1, 0, 0, 0, 32'hBFC00000, 0};
    tbl[9]  = '{0, 0, 1, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        0};
    tbl[10] = '{0, 0, 0, 1, 32'hCAFEF00D, 0, 0, 0, 1, 0, 32'h0,        0};
    tbl[11] = '{0, 0, 1, 1, 32'h0,        0, 0, 0, 0, 0, 32'h0,        0};
    tbl[12] = '{0, 0, 0, 1, 32'h0,        0, 0, 0, 0, 0, 32'h0,        0};

    rst = 1'b0;
    zero_inputs();
    do_reset();

    // Reset state, with stray bus handshakes present in IDLE.
    bus_addr_ok = 1; bus_data_ok = 1;
    #1;
    check("rst_bus_req", bus_req, 0);
    check("rst_inst_aok", inst_addr_ok, 0);
    check("rst_data_aok", data_addr_ok, 0);
    check("rst_inst_dok", inst_data_ok, 0);
    check("rst_data_dok", data_data_ok, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_bus_fields", {bus_wr, bus_size, bus_wstrb}, 0);
    @(negedge clk);

    // Directed table: post-reset tie, back-to-back ties, routing, spurious handshakes.
    do_reset();
    inst_addr = 32'hBFC00000;
    data_addr = 32'h80001000; data_wr = 1; data_size = 2'b10;
    data_wstrb = 4'hF; data_wdata = 32'hDEADBEEF;
    for (int i = 0; i < 13; i++) begin
      inst_req = tbl[i].ireq; data_req = tbl[i].dreq;
      bus_addr_ok = tbl[i].aok; bus_data_ok = tbl[i].dok; bus_rdata = tbl[i].rdata;
      #1;
      check($sformatf("tbl%0d_bus_req", i), bus_req, tbl[i].e_breq);
      check($sformatf("tbl%0d_inst_aok", i), inst_addr_ok, tbl[i].e_iaok);
      check($sformatf("tbl%0d_data_aok", i), data_addr_ok, tbl[i].e_daok);
      check($sformatf("tbl%0d_inst_dok", i), inst_data_ok, tbl[i].e_idok);
      check($sformatf("tbl%0d_data_dok", i), data_data_ok, tbl[i].e_ddok);
      if (tbl[i].e_breq) begin
        check($sformatf("tbl%0d_bus_addr", i), bus_addr, tbl[i].e_addr);
        check($sformatf("tbl%0d_bus_wr", i), bus_wr, tbl[i].e_wr);
      end
      if (tbl[i].e_idok) check($sformatf("tbl%0d_inst_rdata", i), inst_rdata, tbl[i].rdata);
      if (tbl[i].e_ddok) check($sformatf("tbl%0d_data_rdata", i), data_rdata, tbl[i].rdata);
      @(negedge clk);
    end

    // Data write with addr_ok held off for three cycles.
    do_reset();
    data_req = 1; data_wr = 1; data_size = 2'b10; data_wstrb = 4'hF;
    data_addr = 32'h80001000; data_wdata = 32'hDEADBEEF;
    #1;
    check("wr_idle_bus_req", bus_req, 0);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      bus_addr_ok = (k == 3);
      #1;
      check($sformatf("wr%0d_bus_req", k), bus_req, 1);
      check($sformatf("wr%0d_bus_addr", k), bus_addr, 32'h80001000);
      check($sformatf("wr%0d_bus_wdata", k), bus_wdata, 32'hDEADBEEF);
      check($sformatf("wr%0d_bus_wstrb", k), bus_wstrb, 4'hF);
      check($sformatf("wr%0d_bus_wr", k), bus_wr, 1);
      check($sformatf("wr%0d_bus_size", k), bus_size, 2'b10);
      check($sformatf("wr%0d_data_aok", k), data_addr_ok, (k == 3));
      check($sformatf("wr%0d_inst_aok", k), inst_addr_ok, 0);
      @(negedge clk);
    end
    data_req = 0; bus_addr_ok = 0;
    #1;
    check("wr_data_state_bus_req", bus_req, 0);
    check("wr_data_state_aok", data_addr_ok, 0);
    @(negedge clk);
    bus_data_ok = 1;
    #1;
    check("wr_done_data_dok", data_data_ok, 1);
    check("wr_done_inst_dok", inst_data_ok, 0);
    @(negedge clk);

    // Reset while in DATA, then a late data_ok.
    do_reset();
    inst_req = 1; inst_addr = 32'h00400000;
    @(negedge clk);
    inst_req = 0; bus_addr_ok = 1;
    #1;
    check("rmt_inst_aok", inst_addr_ok, 1);
    @(negedge clk);
    bus_addr_ok = 0;
    do_reset();
    bus_data_ok = 1; bus_rdata = 32'h11111111;
    #1;
    check("rmt_inst_dok", inst_data_ok, 0);
    check("rmt_data_dok", data_data_ok, 0);
    check("rmt_bus_req", bus_req, 0);
    @(negedge clk);
    bus_data_ok = 0; inst_req = 1; data_req = 1;
    inst_addr = 32'hBFC00000; data_addr = 32'h80002000;
    #1;
    check("rmt_idle_bus_req", bus_req, 0);
    @(negedge clk);
    #1;
    check("rmt_regrant_bus_req", bus_req, 1);
    check("rmt_regrant_addr", bus_addr, 32'hBFC00000);
    @(negedge clk);

    // Randomized run against the transaction model.
    do_reset();
    m_busy = 0; m_addr_done = 0; m_last = 1'b1; m_own = 0;
    m_wr = 0; m_size = 0; m_wstrb = 0; m_addr = 0; m_wdata = 0;
    ack_i = 0; ack_d = 0;
    for (int c = 0; c < 3000; c++) begin
      if (inst_req && ack_i) inst_req = 0;
      if (!inst_req && $urandom_range(0, 2) == 0) begin
        inst_req = 1; inst_addr = $urandom;
      end
      if (data_req && ack_d) data_req = 0;
      if (!data_req && $urandom_range(0, 2) == 0) begin
        data_req = 1; data_addr = $urandom; data_wdata = $urandom;
        data_wr = $urandom_range(0, 1); data_size = 2'($urandom_range(0, 2));
        data_wstrb = 4'($urandom);
      end
      bus_addr_ok = ($urandom_range(0, 9) < 4);
      bus_data_ok = ($urandom_range(0, 9) < 4);
      bus_rdata   = $urandom;
      #1;
      in_a   = m_busy && !m_addr_done;
      in_d   = m_busy && m_addr_done;
      e_iaok = in_a && bus_addr_ok && !m_own;
      e_daok = in_a && bus_addr_ok && m_own;
      e_idok = in_d && bus_data_ok && !m_own;
      e_ddok = in_d && bus_data_ok && m_own;
      check("rnd_bus_req", bus_req, in_a);
      check("rnd_inst_aok", inst_addr_ok, e_iaok);
      check("rnd_data_aok", data_addr_ok, e_daok);
      check("rnd_inst_dok", inst_data_ok, e_idok);
      check("rnd_data_dok", data_data_ok, e_ddok);
      if (in_a) begin
        check("rnd_bus_addr", bus_addr, m_addr);
        check("rnd_bus_attr", {bus_wr, bus_size, bus_wstrb}, {m_wr, m_size, m_wstrb});
        if (m_own) check("rnd_bus_wdata", bus_wdata, m_wdata);
      end
      if (e_idok) check("rnd_inst_rdata", inst_rdata, bus_rdata);
      if (e_ddok) check("rnd_data_rdata", data_rdata, bus_rdata);
      ack_i = e_iaok;
      ack_d = e_daok;
      if (!m_busy) begin
        if (inst_req || data_req) begin
          m_own = (inst_req && data_req) ? ~m_last : data_req;
          m_last = m_own;
          m_busy = 1; m_addr_done = 0;
          if (m_own) begin
            m_wr = data_wr; m_size = data_size; m_wstrb = data_wstrb;
            m_addr = data_addr; m_wdata = data_wdata;
          end else begin
            m_wr = 0; m_size = 2'b10; m_wstrb = 4'b0000;
            m_addr = inst_addr; m_wdata = 0;
          end
        end
      end else if (!m_addr_done) begin
        if (bus_addr_ok) m_addr_done = 1;
      end else if (bus_data_ok) begin
        m_busy = 0;
      end
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
